// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Round-robin owner of a shared 4:1 single-bit selector with
//            bounded hold time, one turnaround cycle and registered data.
//            Optional per-requester grant counters under ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [3:0]       din,
    output logic [3:0]       gnt,
    output logic             S0,
    output logic             S1,
    output logic             busy,
    output logic             dout
`ifdef ARB_STATS_EN
    ,
    output logic [4*CNT_W-1:0] gnt_cnt
`endif
);

    // Hold counter must reach MAX_HOLD (up to 255) even when CNT_W is narrow.
    localparam int c_HOLD_W = (CNT_W > 8) ? CNT_W : 8;
    localparam logic [c_HOLD_W-1:0] c_MAX_HOLD = c_HOLD_W'(MAX_HOLD);
    localparam logic [c_HOLD_W-1:0] c_ONE      = c_HOLD_W'(1);

    typedef enum logic [1:0] {
        c_ST_IDLE  = 2'd0,
        c_ST_GRANT = 2'd1,
        c_ST_TURN  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_gnt;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_dout;
    logic [1:0]            r_last;
    logic [c_HOLD_W-1:0]   r_hold;

    logic [1:0]            w_win;
    logic [1:0]            w_cand;
    logic                  w_found;
    logic                  w_take;
    logic                  w_others;
    logic                  w_hold_max;
    logic [3:0]            w_owner_oh;

    // Round-robin search: last+1, last+2, last+3, then last itself.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_cand  = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_owner_oh = 4'b0001 << r_last;
    assign w_others   = |(req & ~w_owner_oh);
    assign w_hold_max = (r_hold == c_MAX_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = c_ST_GRANT;
                    w_take      = 1'b1;
                end
            end
            c_ST_GRANT: begin
                if (!req[r_last] || (w_hold_max && w_others)) begin
                    w_state_nxt = c_ST_TURN;
                end
            end
            c_ST_TURN: begin
                if (|req) begin
                    w_state_nxt = c_ST_GRANT;
                    w_take      = 1'b1;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt  <= 4'b0000;
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
            r_last <= 2'd3;
            r_hold <= '0;
            r_dout <= 1'b0;
        end else begin
            r_dout <= (r_gnt != 4'b0000) ? din[r_last] : 1'b0;
            if (w_take) begin
                r_gnt  <= 4'b0001 << w_win;
                r_s0   <= w_win[1];
                r_s1   <= w_win[0];
                r_last <= w_win;
                r_hold <= c_ONE;
            end else if (r_state == c_ST_GRANT && w_state_nxt == c_ST_GRANT) begin
                if (!w_hold_max) begin
                    r_hold <= r_hold + c_ONE;
                end
            end else begin
                r_gnt  <= 4'b0000;
                r_hold <= '0;
            end
        end
    end

    assign gnt  = r_gnt;
    assign S0   = r_s0;
    assign S1   = r_s1;
    assign dout = r_dout;
    assign busy = (r_state != c_ST_IDLE);

`ifdef ARB_STATS_EN
    for (genvar i = 0; i < 4; i++) begin : g_stats
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_take && (w_win == 2'(i)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
        assign gnt_cnt[i*CNT_W +: CNT_W] = r_cnt;
    end
`endif

endmodule
`default_nettype wire
